max_pool_2x2: RTL and testbench
===============================

# max_pool_2x2

Pipelined 2x2 max-pooling unit for the LeNet-5 accelerator datapath. It takes four signed activations from one pooling window and returns their maximum plus the index of the winning input. It sits between the convolution/activation stage and the next layer's feature-map buffer. It accepts one window per clock, with fixed two-cycle latency and no backpressure.

## Interface
- BITWIDTH, default 8: width of each signed two's-complement activation and of the result.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  high when a, b, c, d carry a valid window this cycle.
- a  input  BITWIDTH  signed window element 0 (top-left).
- b  input  BITWIDTH  signed window element 1 (top-right).
- c  input  BITWIDTH  signed window element 2 (bottom-left).
- d  input  BITWIDTH  signed window element 3 (bottom-right).
- max_number  output  BITWIDTH  signed maximum of the window, registered.
- max_idx  output  2  index of the winning element: 0=a, 1=b, 2=c, 3=d.
- out_valid  output  1  high for exactly one cycle per accepted window, aligned with max_number/max_idx.

## Operation
- All comparisons are signed two's-complement at the full BITWIDTH. Inputs are never zero-extended or truncated.
- Stage 1, registered:
  - ab = max(a,b), and its idx is 0 or 1.
  - cd = max(c,d), and its idx is 2 or 3.
  - The in_valid bit is registered alongside.
- Stage 2, registered:
  - max_number = max(ab,cd), with the corresponding idx.
  - out_valid is the registered stage-1 valid.
- Tie-break: on equal values the lower index wins. So a beats b, c beats d, and ab beats cd. Example: all four inputs equal gives max_idx=0.
- Data registers load only when the valid of their stage is high. Otherwise they hold their previous value.
- out_valid follows the pipeline every cycle, regardless of data.
- No internal state beyond the two pipeline stages. Windows are independent.
- No saturation is needed, because the result is always one of the inputs. Exception: the ReLU option below.

## Timing
- Latency: a window presented with in_valid=1 in cycle N appears on max_number/max_idx with out_valid=1 in cycle N+2.
- Throughput: one window per cycle. Back-to-back valids produce back-to-back out_valid.
- Bubbles (in_valid=0) propagate as out_valid=0 two cycles later. Outputs hold their last valid values during bubbles.
- Reset values: max_number=0, max_idx=0, out_valid=0, and all stage-1 registers and valids = 0.
- Reset asserted mid-operation:
  - Immediately, and asynchronously, clears all registers.
  - Any in-flight windows are discarded and never produce out_valid.
- Reset release:
  - The first window can be accepted on the first rising edge with rst_n=1.
  - Its output appears two edges later.

## Configuration
- Macro MAX_POOL_RELU_EN.
- Defined: the stage-2 result is clamped to zero when negative.
  - max_number = 0 whenever the true maximum is below 0.
  - max_idx still reports the index of the true maximum.
  - This fuses ReLU into pooling.
- Undefined, which is the default: max_number is the true signed maximum, including negative values.

## Test plan
- Reset, then a=b=c=d=0 with in_valid=1 -> two cycles later max_number=0, max_idx=0, out_valid=1.
- Sequential valids:
  - a=1,b=2,c=3,d=4 -> 4, idx 3.
  - Then a=-1,b=-2,c=-4,d=-3 -> -1, idx 0 (-1 with ReLU enabled gives 0, idx 0).
  - Then a=4,b=3,c=-8,d=-6 -> 4, idx 0.
  - Check these three cycles back-to-back.
- Extremes at BITWIDTH=8:
  - a=-128,b=127,c=-1,d=0 -> 127, idx 1.
  - All inputs -128 -> -128, idx 0 (0 with ReLU enabled).
- Ties: a=5,b=5,c=5,d=5 -> idx 0. Also a=1,b=2,c=7,d=7 -> 7, idx 2.
- Bubble pattern: in_valid 1,0,1 -> out_valid 1,0,1 with a two-cycle delay. max_number holds its value during the bubble.
- Reset mid-pipeline: assert rst_n=0 one cycle after a valid window -> outputs clear at once, and no out_valid appears after release.

Source files
------------

// File: rtl/max_pool_2x2.sv
// Two-stage 2x2 signed max-pool: pairwise maxima in stage 1, final maximum and index in stage 2.
// Define MAX_POOL_RELU_EN to clamp negative results to zero (ReLU fused into pooling).
module max_pool_2x2 #(
  parameter int BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  input  logic [BITWIDTH-1:0] c,
  input  logic [BITWIDTH-1:0] d,
  output logic [BITWIDTH-1:0] max_number,
  output logic [1:0]          max_idx,
  output logic                out_valid
);

  logic [BITWIDTH-1:0] ab_q, cd_q;
  logic                ab_idx_q, cd_idx_q;
  logic                v1_q;

  logic                a_ge_b, c_ge_d, ab_ge_cd;
  logic [BITWIDTH-1:0] stage2_num;
  logic [1:0]          stage2_idx;

  // ">=" makes the lower index win every tie
  always_comb begin
    a_ge_b   = $signed(a) >= $signed(b);
    c_ge_d   = $signed(c) >= $signed(d);
    ab_ge_cd = $signed(ab_q) >= $signed(cd_q);
  end

  always_comb begin
    stage2_num = ab_ge_cd ? ab_q : cd_q;
    stage2_idx = ab_ge_cd ? {1'b0, ab_idx_q} : {1'b1, cd_idx_q};
`ifdef MAX_POOL_RELU_EN
    // index still reports the true winner even when the value is clamped
    if (stage2_num[BITWIDTH-1]) stage2_num = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q     <= '0;
      cd_q     <= '0;
      ab_idx_q <= 1'b0;
      cd_idx_q <= 1'b0;
      v1_q     <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        ab_q     <= a_ge_b ? a : b;
        ab_idx_q <= ~a_ge_b;
        cd_q     <= c_ge_d ? c : d;
        cd_idx_q <= ~c_ge_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_number <= '0;
      max_idx    <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        max_number <= stage2_num;
        max_idx    <= stage2_idx;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Randomized and directed checks of max_pool_2x2 against a window-level reference model.
module tb_max_pool_2x2;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [BW-1:0] max_number;
  logic [1:0]    max_idx;
  logic          out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v;
    int num;
    int idx;
  } res_t;

  res_t pipe[$];
  int   held_num = 0;
  int   held_idx = 0;

  max_pool_2x2 #(.BITWIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .max_number(max_number), .max_idx(max_idx), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: first element holding the maximum value wins
  function automatic res_t ref_window(input bit v, input int w0, input int w1,
                                      input int w2, input int w3);
    res_t r;
    int   w[4];
    w = '{w0, w1, w2, w3};
    r.v = v; r.num = w[0]; r.idx = 0;
    for (int k = 1; k < 4; k++)
      if (w[k] > r.num) begin r.num = w[k]; r.idx = k; end
`ifdef MAX_POOL_RELU_EN
    if (r.num < 0) r.num = 0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    res_t z;
    z = '{v: 1'b0, num: 0, idx: 0};
    pipe.delete();
    pipe.push_back(z);
    held_num = 0;
    held_idx = 0;
  endtask

  // One clock: drive a window, then check the window from two edges back
  task automatic cycle(input string name, input bit v, input int va, input int vb,
                       input int vc, input int vd);
    res_t e;
    in_valid = v;
    a = BW'(va); b = BW'(vb); c = BW'(vc); d = BW'(vd);
    pipe.push_back(ref_window(v, va, vb, vc, vd));
    @(posedge clk); #1;
    e = pipe.pop_front();
    if (e.v) begin held_num = e.num; held_idx = e.idx; end
    checks += 3;
    if (out_valid !== e.v) begin
      errors++; $display("FAIL %s out_valid: got %0b want %0b", name, out_valid, e.v);
    end
    if (int'($signed(max_number)) !== held_num) begin
      errors++; $display("FAIL %s max_number: got %0d want %0d", name, $signed(max_number), held_num);
    end
    if (int'(max_idx) !== held_idx) begin
      errors++; $display("FAIL %s max_idx: got %0d want %0d", name, max_idx, held_idx);
    end
  endtask

  task automatic check_zero(input string name);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid: got %0b want 0", name, out_valid); end
    if (max_number !== '0) begin errors++; $display("FAIL %s max_number: got %0d want 0", name, $signed(max_number)); end
    if (max_idx !== 2'd0) begin errors++; $display("FAIL %s max_idx: got %0d want 0", name, max_idx); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    model_reset();
    cycle("zero_win", 1, 0, 0, 0, 0);
    cycle("zero_lat", 0, 0, 0, 0, 0);
    cycle("zero_out", 0, 0, 0, 0, 0);
  endtask

  task automatic test_sequence();
    cycle("seq1", 1, 1, 2, 3, 4);
    cycle("seq2", 1, -1, -2, -4, -3);
    cycle("seq3", 1, 4, 3, -8, -6);
    cycle("seq_d1", 0, 0, 0, 0, 0);
    cycle("seq_d2", 0, 0, 0, 0, 0);
  endtask

  task automatic test_extremes();
    cycle("ext1", 1, -128, 127, -1, 0);
    cycle("ext2", 1, -128, -128, -128, -128);
    cycle("ext3", 1, 127, 127, 127, 127);
    cycle("ext4", 1, -127, -128, -128, -127);
    cycle("ext_d1", 0, 9, 9, 9, 9);
    cycle("ext_d2", 0, 0, 0, 0, 0);
  endtask

  task automatic test_ties();
    cycle("tie1", 1, 5, 5, 5, 5);
    cycle("tie2", 1, 1, 2, 7, 7);
    cycle("tie3", 1, 3, 6, 6, 2);
    cycle("tie4", 1, -5, -5, -9, -5);
    cycle("tie_d1", 0, 0, 0, 0, 0);
    cycle("tie_d2", 0, 0, 0, 0, 0);
  endtask

  task automatic test_bubble();
    cycle("bub1", 1, 10, 20, 30, 40);
    cycle("bub2", 0, 99, 99, 99, 99);
    cycle("bub3", 1, 50, -3, 2, 1);
    cycle("bub4", 0, 0, 0, 0, 0);
    cycle("bub5", 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++)
      cycle("rand", ($urandom_range(3) != 0),
            $signed(BW'($urandom)), $signed(BW'($urandom)),
            $signed(BW'($urandom)), $signed(BW'($urandom)));
    cycle("rand_d1", 0, 0, 0, 0, 0);
    cycle("rand_d2", 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    cycle("mid_pre1", 1, 60, 1, 2, 3);
    cycle("mid_pre2", 1, 70, 1, 2, 3);
    cycle("mid_pre3", 1, 1, 2, 3, 80);
    // window mid_pre3 is in stage 1, mid_pre2 is on the outputs
    rst_n = 1'b0;
    #1;
    check_zero("mid_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 4; n++) cycle("mid_after", 0, 0, 0, 0, 0);
    cycle("mid_new", 1, -7, -2, -3, -4);
    cycle("mid_new_d1", 0, 0, 0, 0, 0);
    cycle("mid_new_d2", 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_extremes();
    test_ties();
    test_bubble();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
